// File: rtl/shift_exec_pipe_pkg.sv
// shift_exec_pipe_pkg: shift opcodes, datapath widths and bit-reverse helper
package shift_exec_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W = 5;
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } shift_op_e;
  function automatic logic [DATA_W-1:0] rev32(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/shift_exec_pipe_if.sv
// shift_exec_pipe_if: operand-in and result-out valid/ready channels
interface shift_exec_pipe_if;
  import shift_exec_pipe_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [AMT_W-1:0]  in_amt;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_ovf;
  logic              out_err;
  modport slave (
    input  in_valid, in_x, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf, out_err
  );
  modport master (
    output in_valid, in_x, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf, out_err
  );
endinterface

// File: rtl/shift_exec_pipe_core.sv
// shift_core_r: combinational log-stage right shifter with a fill bit
module shift_core_r
  import shift_exec_pipe_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] y_o
);
  logic [DATA_W-1:0] s [AMT_W+1];
  assign s[0] = x_i;
  genvar i;
  // stage i shifts by 16, 8, 4, 2, 1 in that order
  for (i = 0; i < AMT_W; i++) begin : g_stage
    localparam int N = 1 << (AMT_W - 1 - i);
    assign s[i+1] = amt_i[AMT_W-1-i] ? {{N{fill_i}}, s[i][DATA_W-1:N]} : s[i];
  end
  assign y_o = s[AMT_W];
endmodule

// File: rtl/shift_exec_pipe.sv
// shift_exec_pipe: two-stage valid/ready shift unit (SLL/SRL/SRA) with zero/ovf/err flags
module shift_exec_pipe
  import shift_exec_pipe_pkg::*;
(
  input logic clock,
  input logic reset_n,
  input logic flush,
  shift_exec_pipe_if.slave bus
);
  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s1_x_q;
  logic [AMT_W-1:0]  s1_amt_q;
  logic [1:0]        s1_op_q;
  logic [DATA_W-1:0] s2_res_q, res_d, core_in, core_out, back;
  logic              s2_zero_q, s2_ovf_q, s2_err_q, ovf_d;
  logic              s1_adv, s2_adv, s1_load, s2_load;
  assign s2_adv       = !s2_valid_q | bus.out_ready;
  assign s1_adv       = !s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv & !flush;
  assign s1_load      = bus.in_valid & bus.in_ready;
  assign s2_load      = s1_valid_q & s2_adv & !flush;
  assign s1_valid_d   = s1_load | (s1_valid_q & !s1_adv & !flush);
  assign s2_valid_d   = s2_load | (s2_valid_q & !s2_adv & !flush);
  // left shifts reuse the right shifter by reversing around it
  assign core_in = s1_op_q == OP_SLL ? rev32(s1_x_q) : s1_x_q;
  shift_core_r u_core (
    .x_i    (core_in),
    .amt_i  (s1_amt_q),
    .fill_i (s1_op_q == OP_SRA && s1_x_q[DATA_W-1]),
    .y_o    (core_out)
  );
  assign res_d = s1_op_q == OP_ILL ? '0 : s1_op_q == OP_SLL ? rev32(core_out) : core_out;
  assign back  = $unsigned($signed(res_d) >>> s1_amt_q);
  assign ovf_d = s1_op_q == OP_SLL && back != s1_x_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_amt_q   <= '0;
      s1_op_q    <= '0;
      s2_res_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) {s1_x_q, s1_amt_q, s1_op_q} <= {bus.in_x, bus.in_amt, bus.in_op};
      if (s2_load) {s2_res_q, s2_zero_q, s2_ovf_q, s2_err_q} <= {res_d, res_d == '0, ovf_d, s1_op_q == OP_ILL};
    end
  end
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_res_q;
  assign bus.out_zero   = s2_zero_q;
  assign bus.out_ovf    = s2_ovf_q;
  assign bus.out_err    = s2_err_q;
endmodule

// File: tb/tb_shift_exec_pipe.sv
// tb_shift_exec_pipe: directed + randomized checks against an arithmetic scoreboard
module tb_shift_exec_pipe;
  import shift_exec_pipe_pkg::*;
  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0;
  int errors = 0, checks = 0;
  typedef struct packed {logic [31:0] r; logic z, o, e;} res_t;
  res_t exp_q[$];
  shift_exec_pipe_if bus();
  shift_exec_pipe dut (.clock(clock), .reset_n(reset_n), .flush(flush), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [4:0] a, input logic [1:0] op);
    res_t m;
    longint v;
    case (op)
      2'b00:   m.r = x << a;
      2'b01:   m.r = x >> a;
      2'b10:   m.r = 32'($signed(x) >>> a);
      default: m.r = 32'd0;
    endcase
    v = longint'($signed(x)) * (longint'(1) << a);
    m.z = m.r == 32'd0;
    m.o = op == 2'b00 && (v > 64'sd2147483647 || v < -64'sd2147483648);
    m.e = op == 2'b11;
    return m;
  endfunction

  // scoreboard: retire delivered results, drop in-flight beats on flush, enqueue accepted beats
  always @(negedge clock) if (reset_n) begin
    res_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(bus.out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_result", bus.out_result, e.r);
        check("sb_flags", 32'({bus.out_zero, bus.out_ovf, bus.out_err}), 32'({e.z, e.o, e.e}));
      end
    end
    if (flush) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_x, bus.in_amt, bus.in_op));
  end
  always @(negedge reset_n) exp_q.delete();

  task automatic drive(input logic [31:0] x, input logic [4:0] a, input logic [1:0] op);
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_amt = a;
    bus.in_op = op;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clock); n++; end while (!bus.in_ready && n < 50);
    check("accept", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [4:0] a, input logic [1:0] op);
    drive(x, a, op);
    wait_accept();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] r, input logic [2:0] f);
    int n = 0;
    do begin @(negedge clock); n++; end while (!bus.out_valid && n < 50);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res"}, bus.out_result, r);
    check({tag, "_flags"}, 32'({bus.out_zero, bus.out_ovf, bus.out_err}), 32'(f));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t m1;
    int first, last, cnt;
    logic [4:0] a;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_amt = '0; bus.in_op = '0; bus.out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.out_result, 32'd0);
    check("rst_flags", 32'({bus.out_zero, bus.out_ovf, bus.out_err}), 32'd0);
    #11 reset_n = 1'b1;
    @(negedge clock); check("rst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;

    send(32'h80000000, 5'd4, OP_SRA);
    @(negedge clock); check("lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clock); check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("sra_res", bus.out_result, 32'hF8000000);
    check("sra_flags", 32'({bus.out_zero, bus.out_ovf, bus.out_err}), 32'd0);
    @(posedge clock); #1;

    send(32'h40000001, 5'd1, OP_SLL);  expect_out("sll_ovf", 32'h80000002, 3'b010);
    send(32'h00000003, 5'd4, OP_SLL);  expect_out("sll_ok", 32'h00000030, 3'b000);
    send(32'h80000000, 5'd31, OP_SRL); expect_out("srl_31", 32'h00000001, 3'b000);
    send(32'h12345678, 5'd0, OP_SLL);  expect_out("sll_0", 32'h12345678, 3'b000);
    send(32'hFFFFFFFF, 5'd7, OP_ILL);  expect_out("ill", 32'h00000000, 3'b101);
    send(32'h000000F0, 5'd4, OP_SRL);  expect_out("post_ill", 32'h0000000F, 3'b000);

    first = -1; last = -1; cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive($urandom, 5'($urandom), 2'($urandom_range(0, 2)));
          @(negedge clock); check("stream_ready", 32'(bus.in_ready), 32'd1);
          @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 14; j++) begin
          @(negedge clock);
          if (bus.out_valid) begin
            if (first < 0) first = j;
            last = j;
            cnt++;
          end
        end
      end
    join
    check("stream_cnt", 32'(cnt), 32'd8);
    check("stream_contig", 32'(last - first), 32'd7);
    @(posedge clock); #1;

    bus.out_ready = 1'b0;
    m1 = model(32'h0000ABCD, 5'd8, OP_SLL);
    send(32'h0000ABCD, 5'd8, OP_SLL);
    send(32'hC0000000, 5'd2, OP_SRA);
    drive(32'h00000055, 5'd1, OP_SRL);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold", bus.out_result, m1.r);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("bp_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;

    bus.out_ready = 1'b0;
    send(32'h11111111, 5'd1, OP_SLL);
    send(32'h22222222, 5'd2, OP_SRL);
    drive(32'h33333333, 5'd3, OP_SRA);
    flush = 1'b1;
    @(negedge clock); check("flush_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clock); check("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); check("flush_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clock); #1;

    send($urandom, 5'd3, OP_SRL);
    send($urandom, 5'd5, OP_SLL);
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result", bus.out_result, 32'd0);
    check("arst_flags", 32'({bus.out_zero, bus.out_ovf, bus.out_err}), 32'd0);
    @(posedge clock); #2 reset_n = 1'b1;
    @(negedge clock);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    check("arst_empty", 32'(bus.out_valid), 32'd0);
    @(posedge clock); #1;
    send(32'h00000003, 5'd4, OP_SLL);
    @(negedge clock); check("arst_lat_early", 32'(bus.out_valid), 32'd0);
    @(negedge clock); check("arst_lat_valid", 32'(bus.out_valid), 32'd1);
    check("arst_res", bus.out_result, 32'h00000030);
    @(posedge clock); #1;

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 5'd0;
        1: a = 5'd31;
        default: a = 5'($urandom);
      endcase
      drive($urandom_range(0, 1) ? $urandom : $urandom_range(0, 255), a, 2'($urandom));
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      @(posedge clock); #1;
    end
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1 check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
